conway_matrix_scanner: RTL and testbench
========================================

Name: conway_matrix_scanner

Overview:
Downstream display/step controller for the 8x8 Conway core. Snapshots the core's current_state once per frame and time-multiplexes it row by row onto an 8x8 LED matrix. It also generates the core's registered, glitch-free clk_en pulse, so generations advance only at frame boundaries, either free-running or on single-step request.

Parameters:
ROW_DWELL, 1000, clock cycles each row is driven (>=1)
BLANK_CYCLES, 4, clock cycles row_sel/col_data are forced to 0 before each row (>=2, anti-ghosting and snapshot safety)
FRAMES_PER_GEN, 30, frames per generation when run=1 (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
grid_state  input  64  current_state from the Conway core; bit r*8+c = row r, column c
run  input  1  1 = advance one generation every FRAMES_PER_GEN frames
step_req  input  1  single-step request (level; rising edge counts) when run=0
row_sel  output  8  one-hot row drive; bit r = row r
col_data  output  8  column data for the driven row; bit c = column c
clk_en  output  1  one-cycle generation-advance pulse to the core, driven directly from a flop
frame_done  output  1  one-cycle pulse per completed frame
gen_count  output  16  generations issued since reset, wraps 0xFFFF->0

Behaviour:
- Reset (async, any time, including mid-row): state SCAN_BLANK, row 0, dwell counter 0, frame counter 0, step-pending 0, snapshot 0. All outputs 0 while reset is high and on the first cycle after release.
- FSM per row: SCAN_BLANK for BLANK_CYCLES cycles, then SCAN_DRIVE for ROW_DWELL cycles.
  - After DRIVE of row r<7: go to BLANK of row r+1.
  - After DRIVE of row 7: go to BLANK of row 0.
  - Frame period: 8*(BLANK_CYCLES+ROW_DWELL) cycles.
- Output decode:
  - SCAN_BLANK: row_sel=0, col_data=0.
  - SCAN_DRIVE row r: row_sel=1<<r, col_data=snapshot[r*8+:8].
  - Outputs decode only from registers; no combinational path from inputs.
- Snapshot: grid_state is loaded into the 64-bit snapshot on the edge that moves row 0 from BLANK to DRIVE, and only then. Changes to grid_state mid-frame are not displayed until the next frame (no tearing).
- frame_done: high for exactly the first BLANK cycle of row 0 following row 7's DRIVE. The first frame after reset produces no frame_done at its start.
- Free-running stepping (run=1):
  - Frame counter increments on each frame_done.
  - On the FRAMES_PER_GEN-th frame_done since run was last sampled 1 after being 0 (or since reset), clk_en is high in that same cycle and the counter clears.
  - While run=0 the frame counter is held at 0.
- Single stepping (run=0):
  - A rising edge of step_req sets step-pending.
  - On the next frame_done, clk_en pulses and step-pending clears.
  - Multiple edges before that frame_done collapse to one step.
  - An edge coinciding with frame_done is held pending for the next frame.
  - step_req edges while run=1 are ignored and do not set pending.
- Each clk_en pulse increments gen_count by 1 on the same edge that ends the pulse.
- The core latches the next generation at the edge ending the clk_en cycle. BLANK_CYCLES>=2 guarantees the row-0 snapshot sees the updated state.
- run changing mid-frame does not disturb scanning; only the stepping rules above apply.

Decomposition:
- Shared package conway_pkg:
  - scan_state_t enum {SCAN_BLANK, SCAN_DRIVE}
  - GRID_ROWS=8, GRID_COLS=8
  - localparam GEN_W=16
- One sub-module rise_detect: registered previous value of step_req, one-cycle rising-edge pulse, async active-high reset to 0.
- Counters and FSM live in conway_matrix_scanner.

Test Plan:
All tests use ROW_DWELL=4, BLANK_CYCLES=2, FRAMES_PER_GEN=3, so the frame is 48 cycles. Cycle 0 is the first cycle after reset release.
1. grid_state=64'h0000_0000_0000_00A5, run=0 -> row_sel=0 cycles 0-1; row_sel=8'h01, col_data=8'hA5 cycles 2-5; row_sel=8'h02, col_data=0 cycles 8-11; frame_done only at cycles 48, 96; clk_en never high.
2. As 1, grid_state changed to 64'hFF00_0000_0000_0000 at cycle 10 -> row 7 drive (cycles 44-47) shows col_data=0; next frame row 7 drive (cycles 92-95) shows col_data=8'hFF; row 0 shows 8'h00 from cycle 50.
3. run=1 from reset -> frame_done at 48, 96, 144, 192, 240, 288; clk_en only at 144 and 288; gen_count=1 from cycle 145, =2 from cycle 289.
4. run=0; step_req rising edges at cycles 5 and 20 -> single clk_en at cycle 48, gen_count=1, no clk_en at 96. A further edge at cycle 96 (coincident with frame_done) -> clk_en at 144.
5. run=1; reset pulsed at cycle 30 for one cycle -> all outputs 0 immediately. Scan restarts at row 0 BLANK after release; no frame_done until 48 cycles later; first clk_en on the third subsequent frame_done; gen_count=0.
6. step_req edge at cycle 5 with run=1, run dropped to 0 at cycle 60 -> no clk_en at 48 or 96 (edge ignored, nothing pending).

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and sizes for the Conway display/step controller.
package conway_pkg;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_t;

    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;
    localparam int GEN_W     = 16;

endpackage

// File: rtl/conway_matrix_scanner_if.sv
// Bundle between the Conway core / LED matrix side and the scanner.
interface conway_matrix_scanner_if;
    import conway_pkg::*;

    logic [GRID_ROWS*GRID_COLS-1:0] grid_state;
    logic                           run;
    logic                           step_req;
    logic [GRID_ROWS-1:0]           row_sel;
    logic [GRID_COLS-1:0]           col_data;
    logic                           clk_en;
    logic                           frame_done;
    logic [GEN_W-1:0]               gen_count;

    modport master (
        output grid_state, run, step_req,
        input  row_sel, col_data, clk_en, frame_done, gen_count
    );

    modport slave (
        input  grid_state, run, step_req,
        output row_sel, col_data, clk_en, frame_done, gen_count
    );

endinterface

// File: rtl/conway_matrix_scanner_rise_detect.sv
// One-cycle pulse on each rising edge of a level input.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) din_p0 <= 1'b0;
        else       din_p0 <= din;
    end

    assign rise = din & ~din_p0;

endmodule

// File: rtl/conway_matrix_scanner.sv
// Row-multiplexed LED scanner for the 8x8 Conway core; also paces generations
// through a registered clk_en pulse issued only at frame boundaries.
module conway_matrix_scanner
    import conway_pkg::*;
#(
    parameter int ROW_DWELL      = 1000,
    parameter int BLANK_CYCLES   = 4,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    conway_matrix_scanner_if.slave  bus
);

    localparam int CNT_MAX = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FRM_W   = $clog2(FRAMES_PER_GEN + 1);
    localparam int ROW_W   = $clog2(GRID_ROWS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(ROW_DWELL - 1);
    localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(FRAMES_PER_GEN - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST  = '0;
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(GRID_ROWS - 1);

    scan_state_t                    state_q, state_d;
    logic [ROW_W-1:0]               row_q, row_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           frame_end;
    logic                           snap_load;

    logic [GRID_ROWS*GRID_COLS-1:0] snap_q;
    logic [FRM_W-1:0]               frame_cnt_q;
    logic                           step_pend_q;
    logic                           step_rise;
    logic                           last_frame;
    logic                           fire_run;
    logic                           fire_step;
    logic                           clk_en_p0;
    logic                           frame_done_p0;
    logic [GEN_W-1:0]               gen_q;

    rise_detect u_step_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.step_req),
        .rise  (step_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SCAN_BLANK;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q + 1'b1;
        frame_end = 1'b0;
        snap_load = 1'b0;
        case (state_q)
            SCAN_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d   = SCAN_DRIVE;
                    cnt_d     = '0;
                    snap_load = (row_q == ROW_FIRST);
                end
            end
            SCAN_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d   = SCAN_BLANK;
                    cnt_d     = '0;
                    row_d     = row_q + 1'b1;
                    frame_end = (row_q == ROW_LAST);
                end
            end
            default: begin
                state_d = SCAN_BLANK;
            end
        endcase
    end

    // Step decisions are made on the edge entering row 0 BLANK, so clk_en
    // lands in the same cycle as frame_done.
    assign last_frame = (frame_cnt_q == FRAME_LAST);
    assign fire_run   = frame_end &  bus.run & last_frame;
    assign fire_step  = frame_end & ~bus.run & step_pend_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q        <= '0;
            frame_cnt_q   <= '0;
            step_pend_q   <= 1'b0;
            clk_en_p0     <= 1'b0;
            frame_done_p0 <= 1'b0;
            gen_q         <= '0;
        end else begin
            frame_done_p0 <= frame_end;
            clk_en_p0     <= fire_run | fire_step;
            if (clk_en_p0)
                gen_q <= gen_q + 1'b1;
            if (!bus.run)
                frame_cnt_q <= '0;
            else if (frame_end)
                frame_cnt_q <= last_frame ? '0 : frame_cnt_q + 1'b1;
            // A new edge wins over a concurrent clear so it carries to the next frame.
            if (step_rise && !bus.run)
                step_pend_q <= 1'b1;
            else if (fire_step)
                step_pend_q <= 1'b0;
            if (snap_load)
                snap_q <= bus.grid_state;
        end
    end

    assign bus.row_sel    = (state_q == SCAN_DRIVE) ? ({{(GRID_ROWS-1){1'b0}}, 1'b1} << row_q) : '0;
    assign bus.col_data   = (state_q == SCAN_DRIVE) ? snap_q[{row_q, 3'b000} +: GRID_COLS] : '0;
    assign bus.clk_en     = clk_en_p0;
    assign bus.frame_done = frame_done_p0;
    assign bus.gen_count  = gen_q;

endmodule

// File: tb/tb_conway_matrix_scanner.sv
// Randomized scoreboard bench for conway_matrix_scanner against a frame-arithmetic model.
module tb_conway_matrix_scanner;

    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int FPG   = 3;
    localparam int ROWP  = DWELL + BLANK;
    localparam int FRAME = 8 * ROWP;

    typedef struct packed {
        logic [7:0]  rs;
        logic [7:0]  cd;
        logic        fd;
        logic        ce;
        logic [15:0] gen;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conway_matrix_scanner_if bus_if ();

    conway_matrix_scanner #(
        .ROW_DWELL      (DWELL),
        .BLANK_CYCLES   (BLANK),
        .FRAMES_PER_GEN (FPG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    exp_t sb_q[$];
    exp_t mon_exp, mon_got;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: position in the frame follows from the cycle index.
    int          m_t;
    logic [63:0] m_snap;
    int          m_fcount;
    bit          m_pend, m_fd, m_ce, m_prev_step;
    logic [15:0] m_gen;

    function automatic void model_reset();
        m_t = 0; m_snap = '0; m_fcount = 0; m_pend = 0;
        m_fd = 0; m_ce = 0; m_prev_step = 0; m_gen = '0;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int p, row;
        logic [7:0] one;
        one = 8'd1;
        p   = m_t % FRAME;
        row = p / ROWP;
        e.rs  = ((p % ROWP) >= BLANK) ? (one << row) : 8'h00;
        e.cd  = ((p % ROWP) >= BLANK) ? m_snap[row*8 +: 8] : 8'h00;
        e.fd  = m_fd;
        e.ce  = m_ce;
        e.gen = m_gen;
        return e;
    endfunction

    function automatic void model_advance(input bit r, input bit s, input logic [63:0] g);
        bit rise, fd_n, ce_n;
        rise = s & ~m_prev_step;
        m_prev_step = s;
        if (m_ce) m_gen = m_gen + 16'd1;
        if (m_t % FRAME == BLANK - 1) m_snap = g;
        fd_n = ((m_t + 1) % FRAME == 0);
        ce_n = 0;
        if (fd_n) begin
            if (r) begin
                if (m_fcount + 1 == FPG) begin ce_n = 1; m_fcount = 0; end
                else m_fcount = m_fcount + 1;
            end else if (m_pend) begin
                ce_n = 1; m_pend = 0;
            end
        end
        if (!r) m_fcount = 0;
        if (rise && !r) m_pend = 1;
        m_fd = fd_n;
        m_ce = ce_n;
        m_t  = m_t + 1;
    endfunction

    task automatic cyc(input bit r, input bit s, input logic [63:0] g, input bit rst_v);
        @(posedge clk);
        #1;
        reset = rst_v;
        bus_if.run = r;
        bus_if.step_req = s;
        bus_if.grid_state = g;
        if (rst_v) begin
            model_reset();
            sb_q.push_back('0);
        end else begin
            sb_q.push_back(model_expect());
            model_advance(r, s, g);
        end
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_got = {bus_if.row_sel, bus_if.col_data, bus_if.frame_done, bus_if.clk_en, bus_if.gen_count};
            n_tests++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL scan @%0t row_sel=%h/%h col_data=%h/%h frame_done=%b/%b clk_en=%b/%b gen_count=%0d/%0d (got/required)",
                         $time, mon_got.rs, mon_exp.rs, mon_got.cd, mon_exp.cd, mon_got.fd, mon_exp.fd,
                         mon_got.ce, mon_exp.ce, mon_got.gen, mon_exp.gen);
            end
        end
    end

    initial begin
        logic [63:0] g;
        bit r, s;
        bus_if.run = 1'b0;
        bus_if.step_req = 1'b0;
        bus_if.grid_state = '0;
        model_reset();

        // Static image, run=0
        do_reset();
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 64'h0000_0000_0000_00A5, 1'b0);

        // Mid-frame grid change must wait for the next frame
        do_reset();
        for (int i = 0; i < 110; i++)
            cyc(1'b0, 1'b0, (i < 10) ? 64'h0000_0000_0000_00A5 : 64'hFF00_0000_0000_0000, 1'b0);

        // Free running
        do_reset();
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0);

        // Single steps, including an edge coincident with frame_done
        do_reset();
        for (int i = 0; i < 150; i++)
            cyc(1'b0, ((i >= 5 && i < 8) || (i >= 20 && i < 23) || (i >= 96 && i < 99)), 64'h0F, 1'b0);

        // Asynchronous reset mid-row
        do_reset();
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 64'hC3C3_C3C3_C3C3_C3C3, 1'b0);
        cyc(1'b1, 1'b0, 64'hC3C3_C3C3_C3C3_C3C3, 1'b1);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 64'hC3C3_C3C3_C3C3_C3C3, 1'b0);

        // Step edge while running is ignored
        do_reset();
        for (int i = 0; i < 110; i++) cyc(i < 60, (i >= 5 && i < 8), 64'h8001_8001_8001_8001, 1'b0);

        // Randomized mix of grids, run toggles, step requests and resets
        do_reset();
        g = {$urandom, $urandom};
        r = 1'b0;
        s = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) g = {$urandom, $urandom};
            if ($urandom_range(0, 149) == 0) r = ~r;
            if ($urandom_range(0, 9) == 0) s = ~s;
            cyc(r, s, g, ($urandom_range(0, 699) == 0));
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
